ama_riscv_fwd_scoreboard: RTL and testbench

- Parametrised successor to the two-stage operand forwarding unit.
- Tracks in-flight register writes across NUM_STAGES post-ID pipeline stages, each tagged with its result latency.
- Per source operand: selects the youngest stage whose result is ready, or raises a load-use/multi-cycle stall when the youngest match is not yet ready.
- Sits beside the ID stage; drives operand muxes and the pipeline stall/bubble control.

---
 rtl/ama_riscv_pkg.sv | 23 ++
 rtl/ama_riscv_fwd_src_match.sv | 34 +++
 rtl/ama_riscv_fwd_scoreboard.sv | 104 ++++++++++
 tb/tb_ama_riscv_fwd_scoreboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_pkg.sv
// Shared types and constants for the operand-forwarding scoreboard.
package ama_riscv_pkg;

    localparam int FWD_CNT_W  = 4;
    localparam int FWD_SEL_RF = 0;
    localparam int LAT_ALU    = 0;
    localparam int LAT_LOAD   = 1;

    localparam logic [4:0] RF_X0_ZERO = 5'd0;

    // cnt = remaining stages before the result can be forwarded
    typedef struct packed {
        logic                 vld;
        logic                 we;
        logic [4:0]           rd;
        logic [FWD_CNT_W-1:0] cnt;
    } fwd_entry_t;

    function automatic logic [FWD_CNT_W-1:0] cnt_dec(input logic [FWD_CNT_W-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

endpackage

// File: rtl/ama_riscv_fwd_src_match.sv
// Youngest-match priority scan for one source operand: yields forward select
// or a stall when the youngest in-flight producer is not yet ready.
module ama_riscv_fwd_src_match
    import ama_riscv_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  fwd_entry_t [NUM_STAGES-1:0] entries,
    input  logic [4:0]                  rs,
    input  logic                        rs_used,
    output logic [SEL_W-1:0]            sel,
    output logic                        stall
);

    always_comb begin
        sel   = SEL_W'(FWD_SEL_RF);
        stall = 1'b0;
        // Scan oldest to youngest so the youngest match is the last to assign.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (rs_used && (rs != RF_X0_ZERO) && entries[k].vld && entries[k].we &&
                (entries[k].rd == rs)) begin
                if (entries[k].cnt == '0) begin
                    sel   = SEL_W'(k + 1);
                    stall = 1'b0;
                end else begin
                    sel   = SEL_W'(FWD_SEL_RF);
                    stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ama_riscv_fwd_scoreboard.sv
// Forwarding scoreboard tracking in-flight writes across NUM_STAGES post-ID stages.
// Optional performance counters are enabled with macro FWD_PERF_CNT_EN.
module ama_riscv_fwd_scoreboard
    import ama_riscv_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 2,
    parameter int LAT_W      = 2,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_stall,
    input  logic                     flush,
    input  logic                     issue_valid_id,
    input  logic                     reg_we_id,
    input  logic [4:0]               rd_id,
    input  logic [LAT_W-1:0]         lat_id,
    input  logic [NUM_SRC*5-1:0]     rs_id,
    input  logic [NUM_SRC-1:0]       rs_used_id,
`ifdef FWD_PERF_CNT_EN
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_fwd_cnt,
`endif
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     stall_id
);

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(NUM_STAGES - 1);

    fwd_entry_t [NUM_STAGES-1:0] ent;
    fwd_entry_t [NUM_STAGES-1:0] ent_nxt;
    logic [NUM_SRC-1:0]          src_stall;
    logic [LAT_W-1:0]            lat_clamped;
    logic                        advance;

    assign advance     = !pipe_stall;
    assign lat_clamped = (lat_id > LAT_MAX) ? LAT_MAX : lat_id;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        ama_riscv_fwd_src_match #(
            .NUM_STAGES (NUM_STAGES),
            .SEL_W      (SEL_W)
        ) u_match (
            .entries (ent),
            .rs      (rs_id[s*5 +: 5]),
            .rs_used (rs_used_id[s]),
            .sel     (fwd_sel[s*SEL_W +: SEL_W]),
            .stall   (src_stall[s])
        );
    end

    assign stall_id = issue_valid_id & (|src_stall);

    always_comb begin
        ent_nxt        = ent;
        ent_nxt[0].vld = issue_valid_id & !stall_id & !flush;
        ent_nxt[0].we  = reg_we_id;
        ent_nxt[0].rd  = rd_id;
        ent_nxt[0].cnt = FWD_CNT_W'(lat_clamped);
        for (int k = 1; k < NUM_STAGES; k++) begin
            ent_nxt[k]     = ent[k-1];
            ent_nxt[k].cnt = cnt_dec(ent[k-1].cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent <= '0;
        end else if (advance) begin
            ent <= ent_nxt;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] fwd_now;

    always_comb begin
        fwd_now = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (fwd_sel[s*SEL_W +: SEL_W] != '0) begin
                fwd_now = fwd_now + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else if (advance) begin
            if (stall_id) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end else if (issue_valid_id) begin
                perf_fwd_cnt <= perf_fwd_cnt + fwd_now;
            end
        end
    end
`endif

    lat_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
        issue_valid_id |-> (lat_id <= LAT_MAX));

endmodule

// File: tb/tb_ama_riscv_fwd_scoreboard.sv
// Randomised and directed bench for the forwarding scoreboard against an
// age-based model: a producer is forwardable once its age past EX reaches its latency.
module tb_ama_riscv_fwd_scoreboard;
    import ama_riscv_pkg::*;

    localparam int NS    = 3;
    localparam int NSRC  = 2;
    localparam int LAT_W = 2;
    localparam int SEL_W = $clog2(NS + 1);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  pipe_stall = 1'b0;
    logic                  flush = 1'b0;
    logic                  issue_valid_id = 1'b0;
    logic                  reg_we_id = 1'b0;
    logic [4:0]            rd_id = '0;
    logic [LAT_W-1:0]      lat_id = '0;
    logic [NSRC*5-1:0]     rs_id = '0;
    logic [NSRC-1:0]       rs_used_id = '0;
    logic [NSRC*SEL_W-1:0] fwd_sel;
    logic                  stall_id;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]           perf_stall_cnt;
    logic [31:0]           perf_fwd_cnt;
`endif

    ama_riscv_fwd_scoreboard #(
        .NUM_STAGES (NS),
        .NUM_SRC    (NSRC),
        .LAT_W      (LAT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_stall     (pipe_stall),
        .flush          (flush),
        .issue_valid_id (issue_valid_id),
        .reg_we_id      (reg_we_id),
        .rd_id          (rd_id),
        .lat_id         (lat_id),
        .rs_id          (rs_id),
        .rs_used_id     (rs_used_id),
`ifdef FWD_PERF_CNT_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt),
`endif
        .fwd_sel        (fwd_sel),
        .stall_id       (stall_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        bit we;
        int rd;
        int lat;
    } rec_t;

    rec_t        pipe_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_sel[NSRC];
    bit          exp_stall;
    int unsigned exp_perf_stall = 0;
    int unsigned exp_perf_fwd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        rec_t r;
        r = '{vld: 0, we: 0, rd: 0, lat: 0};
        pipe_q.delete();
        for (int k = 0; k < NS; k++) pipe_q.push_back(r);
    endtask

    // Index in the queue is the age in stages past EX.
    task automatic model_eval();
        int src_rs;
        bit any;
        any = 0;
        for (int s = 0; s < NSRC; s++) begin
            exp_sel[s] = 0;
            src_rs = int'(rs_id[s*5 +: 5]);
            if (rs_used_id[s] && src_rs != 0) begin
                for (int k = 0; k < NS; k++) begin
                    if (pipe_q[k].vld && pipe_q[k].we && pipe_q[k].rd == src_rs) begin
                        if (k >= pipe_q[k].lat) exp_sel[s] = k + 1;
                        else any = 1;
                        break;
                    end
                end
            end
        end
        exp_stall = issue_valid_id && any;
    endtask

    task automatic model_advance();
        rec_t r;
        int   nfwd;
        if (pipe_stall) return;
        nfwd = 0;
        for (int s = 0; s < NSRC; s++) if (exp_sel[s] != 0) nfwd++;
        if (exp_stall) exp_perf_stall++;
        else if (issue_valid_id) exp_perf_fwd += nfwd;
        r.vld = issue_valid_id && !exp_stall && !flush;
        r.we  = reg_we_id;
        r.rd  = int'(rd_id);
        r.lat = (int'(lat_id) > NS - 1) ? NS - 1 : int'(lat_id);
        pipe_q.push_front(r);
        void'(pipe_q.pop_back());
    endtask

    task automatic drive(input bit iv, input bit we, input int rd, input int lat,
                         input int rs0, input int rs1, input int used,
                         input bit ps, input bit fl);
        issue_valid_id = iv;
        reg_we_id      = we;
        rd_id          = 5'(rd);
        lat_id         = LAT_W'(lat);
        rs_id          = {5'(rs1), 5'(rs0)};
        rs_used_id     = NSRC'(used);
        pipe_stall     = ps;
        flush          = fl;
        #1;
        model_eval();
        chk("model_sel0", 32'(fwd_sel[0 +: SEL_W]), 32'(exp_sel[0]));
        chk("model_sel1", 32'(fwd_sel[SEL_W +: SEL_W]), 32'(exp_sel[1]));
        chk("model_stall", 32'(stall_id), 32'(exp_stall));
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    function automatic int sel_of(input int s);
        return int'(fwd_sel[s*SEL_W +: SEL_W]);
    endfunction

    initial begin
        model_clear();
        @(negedge clk);
        #1;
        chk("reset_sel", 32'(fwd_sel), 32'd0);
        chk("reset_stall", 32'(stall_id), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU producer, dependent walks EX -> MEM -> WB -> gone
        drive(1, 1, 5, LAT_ALU, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 5, 0, 1, 0, 0);
        chk("alu_ex_sel", sel_of(0), 1); chk("alu_ex_stall", stall_id, 0); tick();
        drive(1, 0, 0, 0, 5, 0, 1, 0, 0); chk("alu_mem_sel", sel_of(0), 2); tick();
        drive(1, 0, 0, 0, 5, 0, 1, 0, 0); chk("alu_wb_sel", sel_of(0), 3); tick();
        drive(1, 0, 0, 0, 5, 0, 1, 0, 0); chk("alu_gone_sel", sel_of(0), 0); tick();

        // load-use: one stall cycle then forward from MEM
        drive(1, 1, 6, LAT_LOAD, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 6, 2, 0, 0);
        chk("ld_use_stall", stall_id, 1); chk("ld_use_sel", sel_of(1), 0); tick();
        drive(1, 0, 0, 0, 0, 6, 2, 0, 0);
        chk("ld_fwd_stall", stall_id, 0); chk("ld_fwd_sel", sel_of(1), 2); tick();

        // youngest wins
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 7, 0, 1, 0, 0); chk("youngest_sel", sel_of(0), 1); tick();

        // x0 and unused sources never match
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("x0_sel", sel_of(0), 0); chk("x0_stall", stall_id, 0); tick();
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 9, 9, 0, 0, 0);
        chk("unused_sel", 32'(fwd_sel), 0); chk("unused_stall", stall_id, 0); tick();

        // external freeze with a load in EX keeps the stall alive
        drive(1, 1, 10, LAT_LOAD, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 10, 2, 1, 1);
            chk("frozen_stall", stall_id, 1); tick();
        end
        drive(1, 0, 0, 0, 0, 10, 2, 0, 0); chk("unfrozen_stall", stall_id, 1); tick();
        drive(1, 0, 0, 0, 0, 10, 2, 0, 0); chk("unfrozen_sel", sel_of(1), 2); tick();

        // flushed producer is never forwarded
        drive(1, 1, 11, 0, 0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 11, 11, 3, 0, 0);
            chk("flushed_sel", 32'(fwd_sel), 0); tick();
        end

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, NS - 1), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            tick();
        end
`ifdef FWD_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, exp_perf_stall);
        chk("perf_fwd", perf_fwd_cnt, exp_perf_fwd);
`endif

        // mid-cycle reset with every stage holding a producer
        for (int i = 0; i < NS; i++) begin
            drive(1, 1, 12, 0, 0, 0, 0, 0, 0); tick();
        end
        drive(1, 0, 0, 0, 12, 12, 3, 0, 0);
        chk("pre_rst_sel", sel_of(0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(fwd_sel), 0);
        chk("rst_stall", stall_id, 0);
`ifdef FWD_PERF_CNT_EN
        chk("rst_perf_stall", perf_stall_cnt, 0);
        chk("rst_perf_fwd", perf_fwd_cnt, 0);
`endif
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 12, 12, 3, 0, 0);
        chk("post_rst_sel", 32'(fwd_sel), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
